linked_list_fifo_rr_reader: RTL
===============================

Name: linked_list_fifo_rr_reader

Overview:
Dequeue engine for the consumer side of linked_list_fifo. It watches the per-queue empty flags and drives pop/pop_sel using weighted round-robin arbitration with a per-queue burst quantum. Each popped word is captured into a 2-entry output buffer, tagged with its queue id, and presented on a valid/ready stream. It never pops an empty or disabled queue, so it satisfies the shared FIFO's pop-side environment constraints by construction.

Parameters:
WIDTH, 4, data word width; must match linked_list_fifo.
NUM_FIFOS, 2, number of logical queues in the shared FIFO; must be at least 2.
SEL_WIDTH, $clog2(NUM_FIFOS), width of the queue select and queue id.
QUANTUM, 2, maximum consecutive pops from one queue before rotating; must be at least 1.
QW, $clog2(QUANTUM+1), width of the burst counter.

Ports:
clk  in  1  clock
rst  in  1  reset
fifo_empty  in  NUM_FIFOS  per-queue empty flags from linked_list_fifo
fifo_data_out  in  WIDTH  head word of queue fifo_pop_sel (combinational, same cycle)
fifo_pop  out  1  pop strobe to linked_list_fifo
fifo_pop_sel  out  SEL_WIDTH  queue being popped
queue_en  in  NUM_FIFOS  per-queue enable; a disabled queue is never popped
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the word
out_data  out  WIDTH  output word
out_qid  out  SEL_WIDTH  source queue of out_data
busy  out  1  output buffer non-empty, or any enabled queue non-empty

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values:
  - cur = 0, burst_cnt = 0, buffer occupancy = 0.
  - out_valid = 0; out_data and out_qid = 0.
  - fifo_pop = 0 during reset.
- Eligibility: elig[i] = ~fifo_empty[i] & queue_en[i].
- Space: space = (occ < 2), using registered occupancy only. There is no combinational path from out_ready to fifo_pop.
- Selection (combinational):
  - If elig[cur] and burst_cnt < QUANTUM, then sel = cur.
  - Otherwise sel = first eligible index in cur+1 .. cur+NUM_FIFOS-1, searched mod NUM_FIFOS.
  - Otherwise, if elig[cur] (quantum exhausted, no other queue eligible), sel = cur.
- Pop rule:
  - fifo_pop = ~rst & space & (|elig).
  - fifo_pop_sel = sel whenever fifo_pop = 1; it holds the last value otherwise.
- On a pop:
  - cur <= sel.
  - burst_cnt <= burst_cnt + 1 if sel == cur and burst_cnt < QUANTUM; else burst_cnt <= 1.
- With no pop, cur and burst_cnt hold.
- Capture: fifo_data_out and sel are written into the buffer tail in the pop cycle. out_valid rises the next cycle, so pop-to-out latency is 1.
- Buffer: 2-entry FIFO, head drives out_data/out_qid, out_valid = (occ != 0).
  - Simultaneous write and accept: occupancy unchanged, order preserved.
  - Throughput is 1 word/cycle when out_ready stays high.
  - When out_ready is low: at most 2 words are captured, then popping stops.
- Stall rule: out_data and out_qid stay stable while out_valid & ~out_ready.
- Empty flags: fifo_empty is taken as accurate every cycle, including the cycle after a pop of a queue's last entry. The block needs no look-ahead.
- queue_en deasserted mid-burst: the queue is ineligible the same cycle; arbitration moves on, and burst_cnt resets on the next pop.
- Reset mid-operation: buffered words are discarded. No pop is issued in the reset cycle, and arbitration restarts at queue 0.
- Arithmetic:
  - burst_cnt saturates at QUANTUM.
  - Index wrap uses mod NUM_FIFOS. It must be correct for non-power-of-2 NUM_FIFOS (e.g. 3).

Decomposition:
- Shared package ll_fifo_pkg holds the width helpers (SEL_WIDTH, PTR_WIDTH derivation) and the queue-id type, so they are common with linked_list_fifo and the proof harness.
- One sub-module: ll_out_buf, a 2-entry valid/ready buffer parameterized on WIDTH+SEL_WIDTH.
- The arbiter stays inline as a function in linked_list_fifo_rr_reader.

Test Plan:
- Single queue: NUM_FIFOS=2, queue 0 holds A,B,C, queue 1 empty, out_ready=1 → pops on 3 consecutive cycles, all with sel=0. Outputs A,B,C with qid 0 on cycles 1..3 after the first pop; the quantum rolls over with no bubble.
- Weighted round-robin: QUANTUM=2, queue 0 holds 4 words, queue 1 holds 4 words, out_ready=1 → qid sequence 0,0,1,1,0,0,1,1 with no idle cycles.
- Backpressure: out_ready=0 with 5 words available → exactly 2 pops, then fifo_pop=0. out_data holds the first word. Raising out_ready resumes 1 word/cycle with order intact.
- Last-entry pop: queue 1 holds 1 word, queue 0 empty → exactly one pop; fifo_pop=0 the next cycle. Assertion: never pop while fifo_empty[pop_sel]=1.
- Disable mid-burst: queue 0 has 3 words and queue 1 has 2, QUANTUM=2; drop queue_en[0] after the first pop → next pops come from queue 1. Re-enabling drains queue 0's remaining 2 words.
- Reset with the buffer holding 2 words → out_valid=0 the cycle after reset, no pop in the reset cycle, first post-reset pop selects the lowest eligible index starting from 0.

Source files
------------

// File: rtl/ll_fifo_pkg.sv
// ll_fifo_pkg
// Shared definitions for linked_list_fifo, its consumer-side reader and the
// proof harness. This package keeps the width derivations and the queue-id
// type in one place, so every user sizes its selects the same way.
//   sel_width(n)  : width of a queue select for n queues (minimum 1)
//   ptr_width(d)  : width of an entry pointer for a d-deep store (minimum 1)
//   qid_t         : queue-id type for the default queue count
package ll_fifo_pkg;

    function automatic int sel_width(input int num_fifos);
        return (num_fifos > 1) ? $clog2(num_fifos) : 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEFAULT_NUM_FIFOS = 2;
    localparam int DEFAULT_SEL_WIDTH = sel_width(DEFAULT_NUM_FIFOS);

    typedef logic [DEFAULT_SEL_WIDTH-1:0] qid_t;

endpackage

// File: rtl/ll_out_buf.sv
// ll_out_buf
// Two-entry valid/ready skid buffer. A write and a read in the same cycle
// leave the occupancy unchanged and keep the order. The head entry stays
// fixed until it is read, so rd_data is stable while it is stalled.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : write request (ignored while full)
//   wr_data   : word written at the tail
//   full      : both entries occupied (registered)
//   rd_valid  : head entry valid
//   rd_ready  : consumer accepts the head entry
//   rd_data   : head entry
module ll_out_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   occ;
    logic         wr_fire;
    logic         rd_fire;

    assign full     = occ[1];
    assign rd_valid = (occ != 2'd0);
    assign rd_data  = mem[rd_ptr];
    assign wr_fire  = wr_en & ~full;
    assign rd_fire  = rd_valid & rd_ready;

    // NOTE: state updates use non-blocking assignments, so every read in this
    // block sees the value from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the two storage words are reset because the head drives the
            // output directly, and the output must read as zero after reset.
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_fire) rd_ptr <= ~rd_ptr;
            case ({wr_fire, rd_fire})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/linked_list_fifo_rr_reader.sv
// linked_list_fifo_rr_reader
// Consumer-side dequeue engine for linked_list_fifo. It runs a weighted
// round-robin over the eligible queues (non-empty and enabled), with up to
// QUANTUM back-to-back pops from one queue. Each popped word is tagged with
// its queue id and goes into a 2-entry output buffer. Popping depends only on
// the registered buffer occupancy, so there is no path from out_ready to
// fifo_pop.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   fifo_empty     : per-queue empty flags from the shared FIFO
//   fifo_data_out  : head word of queue fifo_pop_sel (same cycle)
//   fifo_pop       : pop strobe to the shared FIFO
//   fifo_pop_sel   : queue being popped (holds its value when idle)
//   queue_en       : per-queue enable
//   out_valid/out_ready/out_data/out_qid : output stream with source queue id
//   busy           : buffer holds data or an enabled queue is non-empty
module linked_list_fifo_rr_reader
    import ll_fifo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = sel_width(NUM_FIFOS),
    parameter int QUANTUM   = 2,
    parameter int QW        = $clog2(QUANTUM + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data_out,
    output logic                 fifo_pop,
    output logic [SEL_WIDTH-1:0] fifo_pop_sel,
    input  logic [NUM_FIFOS-1:0] queue_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_qid,
    output logic                 busy
);

    localparam logic [QW-1:0] QUANTUM_Q = QW'(QUANTUM);

    logic [NUM_FIFOS-1:0] elig;
    logic [SEL_WIDTH-1:0] cur;
    logic [SEL_WIDTH-1:0] sel;
    logic [SEL_WIDTH-1:0] last_sel;
    logic [QW-1:0]        burst_cnt;
    logic                 buf_full;

    // Stay on the current queue while it has quantum left. Otherwise take the
    // next eligible queue after it, wrapping around. Fall back to the current
    // queue only if nothing else is eligible.
    function automatic logic [SEL_WIDTH-1:0] pick(
        input logic [NUM_FIFOS-1:0] e,
        input logic [SEL_WIDTH-1:0] c,
        input logic [QW-1:0]        b
    );
        logic                 found;
        logic [SEL_WIDTH-1:0] res;
        int                   idx;
        // NOTE: every local gets a value before any branch, so no path can
        // leave a variable unassigned and infer storage.
        res   = c;
        found = e[c] && (b < QUANTUM_Q);
        for (int k = 1; k < NUM_FIFOS; k++) begin
            idx = int'(c) + k;
            // Wrap by subtraction, which is correct for any queue count.
            if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
            if (!found && e[idx]) begin
                res   = SEL_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign elig         = ~fifo_empty & queue_en;
    assign sel          = pick(elig, cur, burst_cnt);
    assign fifo_pop     = ~rst & ~buf_full & (|elig);
    assign fifo_pop_sel = fifo_pop ? sel : last_sel;
    assign busy         = out_valid | (|elig);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            burst_cnt <= '0;
            last_sel  <= '0;
        end else if (fifo_pop) begin
            cur       <= sel;
            last_sel  <= sel;
            // The count restarts at 1 when the queue changes, and also when
            // the same queue is chosen again after its quantum ran out.
            burst_cnt <= (sel == cur && burst_cnt < QUANTUM_Q) ? burst_cnt + QW'(1) : QW'(1);
        end
    end

    ll_out_buf #(
        .W(WIDTH + SEL_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_pop),
        .wr_data  ({sel, fifo_data_out}),
        .full     (buf_full),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  ({out_qid, out_data})
    );

endmodule
